// File: rtl/video_pkg.sv
// video_pkg
//   Shared constants and types for the Super Hi-Res scanline prefetcher.
//   Contents:
//     ADDR_W          fastram byte-address width
//     SHR_LINE_BYTES  pixel bytes per Super Hi-Res line
//     SHR_LINES       number of valid line numbers
//     SHR_PIX_BASE    RAM address of line 0, pixel byte 0
//     SHR_SCB_BASE    RAM address of the SCB byte for line 0
//     fetch_state_e   line-fetch FSM states
package video_pkg;

    localparam int unsigned ADDR_W = 23;

    localparam int unsigned        SHR_LINE_BYTES = 160;
    localparam int unsigned        SHR_LINES      = 200;
    localparam logic [ADDR_W-1:0]  SHR_PIX_BASE   = 23'h012000;
    localparam logic [ADDR_W-1:0]  SHR_SCB_BASE   = 23'h019D00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCB   = 2'd1,
        ST_PIX   = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/line_buffer_2x.sv
// line_buffer_2x
//   Ping-pong line store: two LINE_BYTES x 8 pixel banks plus one SCB
//   register per bank. One side is filled while the other is displayed.
//   Ports:
//     clk_i       clock
//     rst_ni      asynchronous active-low reset (read registers only)
//     wr_en_i     write strobe
//     wr_scb_i    1: write goes to the SCB register, 0: to pixel wr_idx_i
//     wr_sel_i    bank being filled
//     wr_idx_i    pixel index within the bank
//     wr_data_i   byte to write
//     rd_sel_i    bank being displayed
//     rd_idx_i    display pixel index
//     rd_data_o   registered display byte (0 for indexes past the line)
//     rd_scb_o    registered SCB of the display bank
module line_buffer_2x #(
    parameter int unsigned LINE_BYTES = 160
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       wr_en_i,
    input  logic       wr_scb_i,
    input  logic       wr_sel_i,
    input  logic [7:0] wr_idx_i,
    input  logic [7:0] wr_data_i,
    input  logic       rd_sel_i,
    input  logic [7:0] rd_idx_i,
    output logic [7:0] rd_data_o,
    output logic [7:0] rd_scb_o
);

    logic [7:0] bank_q [2][LINE_BYTES];
    logic [7:0] scb_q  [2];
    logic [7:0] rd_data_q;
    logic [7:0] rd_scb_q;

    // Storage carries no reset; its contents are meaningless until filled.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            if (wr_scb_i) begin
                scb_q[wr_sel_i] <= wr_data_i;
            end else begin
                bank_q[wr_sel_i][wr_idx_i] <= wr_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= 8'h00;
            rd_scb_q  <= 8'h00;
        end else begin
            rd_data_q <= (32'(rd_idx_i) < LINE_BYTES) ? bank_q[rd_sel_i][rd_idx_i] : 8'h00;
            rd_scb_q  <= scb_q[rd_sel_i];
        end
    end

    assign rd_data_o = rd_data_q;
    assign rd_scb_o  = rd_scb_q;

endmodule

// File: rtl/video_line_fetch.sv
// video_line_fetch
//   Copies one Super Hi-Res line (SCB byte + LINE_BYTES pixels) from the
//   dpram video port into the fill half of a ping-pong buffer during hblank;
//   the vdc reads the display half by index.
//   Ports:
//     clk_vid       clock
//     reset_n       asynchronous active-low reset
//     line_start    pulse: fetch line line_num into the fill buffer
//     line_num      line to fetch
//     swap          pulse: fill buffer becomes display buffer
//     ram_addr      read address to dpram port B
//     ram_data      read data, RAM_LAT cycles after ram_addr
//     rd_idx        display byte index
//     rd_data       display byte, one cycle after rd_idx
//     rd_scb        SCB of the display buffer
//     busy          fetch in progress
//     fill_ok       fill buffer holds a complete, unswapped line
//     err_overrun   sticky: line_start while busy
//     err_underrun  sticky: swap without a complete line
module video_line_fetch
    import video_pkg::*;
#(
    parameter int unsigned       LINE_BYTES = SHR_LINE_BYTES,
    parameter int unsigned       LINES      = SHR_LINES,
    parameter logic [ADDR_W-1:0] PIX_BASE   = SHR_PIX_BASE,
    parameter logic [ADDR_W-1:0] SCB_BASE   = SHR_SCB_BASE,
    parameter int unsigned       RAM_LAT    = 1
) (
    input  logic              clk_vid,
    input  logic              reset_n,
    input  logic              line_start,
    input  logic [7:0]        line_num,
    input  logic              swap,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_data,
    input  logic [7:0]        rd_idx,
    output logic [7:0]        rd_data,
    output logic [7:0]        rd_scb,
    output logic              busy,
    output logic              fill_ok,
    output logic              err_overrun,
    output logic              err_underrun
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [1:0]        dcnt_q, dcnt_d;
    logic              busy_q, busy_d;
    logic              fill_ok_q, fill_ok_d;
    logic              err_ov_q, err_ov_d;
    logic              err_un_q, err_un_d;
    logic              disp_sel_q, disp_sel_d;

    // Tag pipe: stage 0 describes the address currently on ram_addr; stage
    // RAM_LAT lines up with its returned byte on ram_data.
    logic [RAM_LAT:0]  vld_p_q;
    logic              vld_p0_d;
    logic [7:0]        idx_p_q [RAM_LAT+1];
    logic              scb_p_q [RAM_LAT+1];
    logic [7:0]        idx_p0_d;
    logic              scb_p0_d;

    always_comb begin
        state_d    = state_q;
        ram_addr_d = ram_addr_q;
        base_d     = base_q;
        dcnt_d     = dcnt_q;
        busy_d     = busy_q;
        fill_ok_d  = fill_ok_q;
        err_ov_d   = err_ov_q;
        err_un_d   = err_un_q;
        disp_sel_d = disp_sel_q;
        vld_p0_d   = 1'b0;
        scb_p0_d   = 1'b0;
        idx_p0_d   = idx_p_q[0];

        unique case (state_q)
            ST_IDLE: begin
                if (line_start && (32'(line_num) < LINES)) begin
                    state_d    = ST_SCB;
                    busy_d     = 1'b1;
                    fill_ok_d  = 1'b0;
                    base_d     = PIX_BASE + ADDR_W'(32'(line_num) * LINE_BYTES);
                    ram_addr_d = SCB_BASE + ADDR_W'(line_num);
                    vld_p0_d   = 1'b1;
                    scb_p0_d   = 1'b1;
                end
            end
            ST_SCB: begin
                state_d    = ST_PIX;
                ram_addr_d = base_q;
                vld_p0_d   = 1'b1;
                idx_p0_d   = 8'd0;
            end
            ST_PIX: begin
                // idx_p_q[0] doubles as the address counter: it is the
                // pixel index of the address now on ram_addr.
                if (idx_p_q[0] == 8'(LINE_BYTES - 1)) begin
                    state_d = ST_DRAIN;
                    dcnt_d  = 2'(RAM_LAT - 1);
                end else begin
                    ram_addr_d = base_q + ADDR_W'(idx_p_q[0] + 8'd1);
                    vld_p0_d   = 1'b1;
                    idx_p0_d   = idx_p_q[0] + 8'd1;
                end
            end
            ST_DRAIN: begin
                if (dcnt_q == 2'd0) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    fill_ok_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q - 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (line_start && busy_q) begin
            err_ov_d = 1'b1;
        end

        // Decided on the registered fill_ok: a swap in the completion cycle
        // still sees 0 and underruns, while the completion sets fill_ok.
        if (swap) begin
            if (fill_ok_q) begin
                disp_sel_d = ~disp_sel_q;
                fill_ok_d  = 1'b0;
            end else begin
                err_un_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ram_addr_q <= '0;
            dcnt_q     <= 2'd0;
            busy_q     <= 1'b0;
            fill_ok_q  <= 1'b0;
            err_ov_q   <= 1'b0;
            err_un_q   <= 1'b0;
            disp_sel_q <= 1'b0;
            vld_p_q    <= '0;
        end else begin
            state_q    <= state_d;
            ram_addr_q <= ram_addr_d;
            dcnt_q     <= dcnt_d;
            busy_q     <= busy_d;
            fill_ok_q  <= fill_ok_d;
            err_ov_q   <= err_ov_d;
            err_un_q   <= err_un_d;
            disp_sel_q <= disp_sel_d;
            vld_p_q    <= {vld_p_q[RAM_LAT-1:0], vld_p0_d};
        end
    end

    always_ff @(posedge clk_vid) begin
        base_q     <= base_d;
        idx_p_q[0] <= idx_p0_d;
        scb_p_q[0] <= scb_p0_d;
        for (int i = 1; i <= RAM_LAT; i++) begin
            idx_p_q[i] <= idx_p_q[i-1];
            scb_p_q[i] <= scb_p_q[i-1];
        end
    end

    // Read side sees the post-swap selection so the byte registered on the
    // swap edge already comes from the new display buffer.
    line_buffer_2x #(
        .LINE_BYTES (LINE_BYTES)
    ) u_buf (
        .clk_i     (clk_vid),
        .rst_ni    (reset_n),
        .wr_en_i   (vld_p_q[RAM_LAT]),
        .wr_scb_i  (scb_p_q[RAM_LAT]),
        .wr_sel_i  (~disp_sel_q),
        .wr_idx_i  (idx_p_q[RAM_LAT]),
        .wr_data_i (ram_data),
        .rd_sel_i  (disp_sel_d),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data),
        .rd_scb_o  (rd_scb)
    );

    assign ram_addr     = ram_addr_q;
    assign busy         = busy_q;
    assign fill_ok      = fill_ok_q;
    assign err_overrun  = err_ov_q;
    assign err_underrun = err_un_q;

endmodule

// File: tb/tb_video_line_fetch.sv
module tb_video_line_fetch;

    localparam logic [22:0] PIX_BASE = 23'h012000;
    localparam logic [22:0] SCB_BASE = 23'h019D00;

    logic        clk_vid;
    logic        reset_n;
    logic        line_start;
    logic [7:0]  line_num;
    logic        swap;
    logic [22:0] ram_addr;
    logic [7:0]  ram_data;
    logic [7:0]  rd_idx;
    logic [7:0]  rd_data;
    logic [7:0]  rd_scb;
    logic        busy;
    logic        fill_ok;
    logic        err_overrun;
    logic        err_underrun;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] line;
        logic [7:0] idx;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [15];

    video_line_fetch dut (
        .clk_vid      (clk_vid),
        .reset_n      (reset_n),
        .line_start   (line_start),
        .line_num     (line_num),
        .swap         (swap),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .rd_idx       (rd_idx),
        .rd_data      (rd_data),
        .rd_scb       (rd_scb),
        .busy         (busy),
        .fill_ok      (fill_ok),
        .err_overrun  (err_overrun),
        .err_underrun (err_underrun)
    );

    initial clk_vid = 1'b0;
    always #5 clk_vid = ~clk_vid;

    // dpram port B with one cycle of latency; SCB region preloaded with a
    // different pattern so SCB and pixel bytes cannot be confused.
    function automatic logic [7:0] ram_model(input logic [22:0] a);
        if (a >= SCB_BASE && a < SCB_BASE + 23'd200) return a[7:0] ^ 8'hA5;
        return a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clk_vid) ram_data <= ram_model(ram_addr);

    task automatic tick();
        @(posedge clk_vid);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_line(input logic [7:0] ln);
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].line == ln) begin
                rd_idx = vecs[i].idx;
                tick();
                check($sformatf("rd_line%0d_idx%0h", ln, vecs[i].idx), rd_data, vecs[i].exp);
            end
        end
    endtask

    // Launches a fetch and follows it until busy falls (bounded), checking
    // every issued address. Optionally pulses line_start or swap at cycle n.
    task automatic fetch_line(input int ln, input int ovr_at, input int swap_at, output int ncyc);
        logic [22:0] base;
        int n;
        base       = PIX_BASE + 23'(ln * 160);
        line_num   = 8'(ln);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        n = 0;
        while (busy && n < 400) begin
            if (n == 0) check("addr_scb", 32'(ram_addr), 32'(SCB_BASE + 23'(ln)));
            else if (n <= 160) check($sformatf("addr_pix%0d", n - 1), 32'(ram_addr), 32'(base + 23'(n - 1)));
            line_start = (n == ovr_at);
            line_num   = (n == ovr_at) ? 8'd3 : 8'(ln);
            swap       = (n == swap_at);
            n++;
            tick();
            line_start = 1'b0;
            swap       = 1'b0;
        end
        line_num = 8'(ln);
        ncyc = n;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ncyc;
        logic [22:0] hold_addr;

        vecs[0]  = '{8'd0,   8'h00, 8'h5A};
        vecs[1]  = '{8'd0,   8'h05, 8'h5F};
        vecs[2]  = '{8'd0,   8'h10, 8'h4A};
        vecs[3]  = '{8'd0,   8'h80, 8'hDA};
        vecs[4]  = '{8'd0,   8'h9F, 8'hC5};
        vecs[5]  = '{8'd0,   8'hA0, 8'h00};
        vecs[6]  = '{8'd0,   8'hFF, 8'h00};
        vecs[7]  = '{8'd199, 8'h00, 8'h3A};
        vecs[8]  = '{8'd199, 8'h20, 8'hDA};
        vecs[9]  = '{8'd199, 8'h9F, 8'hA5};
        vecs[10] = '{8'd199, 8'hA0, 8'h00};
        vecs[11] = '{8'd5,   8'h00, 8'h7A};
        vecs[12] = '{8'd5,   8'h03, 8'h79};
        vecs[13] = '{8'd5,   8'h9F, 8'hE5};
        vecs[14] = '{8'd5,   8'hFF, 8'h00};

        reset_n    = 1'b0;
        line_start = 1'b0;
        line_num   = 8'd0;
        swap       = 1'b0;
        rd_idx     = 8'd0;
        #23;
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_rd_scb", 32'(rd_scb), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_fill_ok", 32'(fill_ok), 32'h0);
        check("rst_err_ov", 32'(err_overrun), 32'h0);
        check("rst_err_un", 32'(err_underrun), 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // Line 0: full address sequence and fetch length.
        rd_idx = 8'd5;
        fetch_line(0, -1, -1, ncyc);
        check("busy_cycles_l0", 32'(ncyc), 32'd162);
        check("fill_ok_l0", 32'(fill_ok), 32'h1);
        check("hold_addr_l0", 32'(ram_addr), 32'h01209F);

        // Swap in line 0.
        swap = 1'b1;
        tick();
        swap = 1'b0;
        check("swap_rd_data", 32'(rd_data), 32'h5F);
        check("swap_rd_scb", 32'(rd_scb), 32'hA5);
        check("swap_fill_ok", 32'(fill_ok), 32'h0);
        check("swap_err_un", 32'(err_underrun), 32'h0);
        check_line(8'd0);

        // Line 199 with a line_start and a swap arriving mid-fetch.
        rd_idx = 8'h05;
        fetch_line(199, 10, 20, ncyc);
        check("busy_cycles_l199", 32'(ncyc), 32'd162);
        check("err_ov_set", 32'(err_overrun), 32'h1);
        check("err_un_set", 32'(err_underrun), 32'h1);
        check("fill_ok_l199", 32'(fill_ok), 32'h1);
        check("hold_addr_l199", 32'(ram_addr), 32'h019CFF);
        check("old_scb_kept", 32'(rd_scb), 32'hA5);
        check_line(8'd0);
        swap = 1'b1;
        tick();
        swap = 1'b0;
        check("swap2_rd_scb", 32'(rd_scb), 32'h62);
        check("swap2_fill_ok", 32'(fill_ok), 32'h0);
        check_line(8'd199);

        // Out-of-range line number is ignored.
        hold_addr  = ram_addr;
        line_num   = 8'd200;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        check("l200_busy", 32'(busy), 32'h0);
        repeat (3) tick();
        check("l200_busy_later", 32'(busy), 32'h0);
        check("l200_addr", 32'(ram_addr), 32'(hold_addr));

        // Reset in the middle of the pixel phase.
        line_num   = 8'd2;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (50) tick();
        check("mid_busy", 32'(busy), 32'h1);
        check("mid_addr", 32'(ram_addr), 32'h012171);
        reset_n = 1'b0;
        #1;
        check("mrst_ram_addr", 32'(ram_addr), 32'h0);
        check("mrst_busy", 32'(busy), 32'h0);
        check("mrst_rd_data", 32'(rd_data), 32'h0);
        check("mrst_rd_scb", 32'(rd_scb), 32'h0);
        check("mrst_err_ov", 32'(err_overrun), 32'h0);
        check("mrst_err_un", 32'(err_underrun), 32'h0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("post_rst_addr", 32'(ram_addr), 32'h0);
        check("post_rst_busy", 32'(busy), 32'h0);
        check("post_rst_fill_ok", 32'(fill_ok), 32'h0);

        // Line 5 with a swap landing on the completion edge: it underruns,
        // the line stays pending, and the following swap shows it.
        fetch_line(5, -1, 161, ncyc);
        check("busy_cycles_l5", 32'(ncyc), 32'd162);
        check("corner_fill_ok", 32'(fill_ok), 32'h1);
        check("corner_err_un", 32'(err_underrun), 32'h1);
        check("corner_err_ov", 32'(err_overrun), 32'h0);
        rd_idx = 8'h00;
        swap   = 1'b1;
        tick();
        swap   = 1'b0;
        check("swap3_rd_data", 32'(rd_data), 32'h7A);
        check("swap3_rd_scb", 32'(rd_scb), 32'hA0);
        check("swap3_fill_ok", 32'(fill_ok), 32'h0);
        check_line(8'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
